cmp_decision_sampler: RTL

Digital back end for the differential active-load comparator. It arms the comparator, synchronises its asynchronous `outpn`/`outnn`/`outxor` outputs into the `clk` domain, and waits for each decision to resolve. Over a programmed burst of N decisions it counts the ones and the timeouts, then hands the totals downstream with a valid/ready handshake. It sits between the comparator macro and the calibration/readout logic.

---
 rtl/cmp_pkg.sv | 33 +++
 rtl/cmp_sync.sv | 29 ++
 rtl/cmp_decision_sampler.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/cmp_pkg.sv
// cmp_pkg
// Shared types and constants for the comparator decision sampler.
//   cmp_state_e  : FSM state encoding (IDLE, ARM, FLUSH, WAIT, DONE)
//   DEF_*        : default parameter values for the sampler
//   cmp_result_t : burst totals {ones, timeouts} at the default counter width
//   max3()       : elaboration-time helper for sizing the phase timer
package cmp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_FLUSH = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } cmp_state_e;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_CNT_W       = 8;
    localparam int DEF_RST_CYC     = 2;
    localparam int DEF_TIMEOUT     = 15;

    typedef struct packed {
        logic [DEF_CNT_W-1:0] ones;
        logic [DEF_CNT_W-1:0] timeouts;
    } cmp_result_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cmp_sync.sv
// cmp_sync
// N-stage flop synchroniser bringing an asynchronous level into the clk domain.
// Ports:
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears the whole chain
//   d_i   : asynchronous input
//   q_o   : synchronised output (last stage of the chain)
module cmp_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/cmp_decision_sampler.sv
// cmp_decision_sampler
// Arms the differential comparator, synchronises its outputs and counts the
// resolved ones and the timeouts over a burst of n_samples decisions, then
// presents the totals with a valid/ready handshake.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   start, n_samples      : burst request and length (accepted in IDLE only)
//   busy                  : burst in progress
//   cmp_pn/cmp_nn/cmp_xor : raw asynchronous comparator outputs
//   cmp_rst               : comparator equalise/arm strobe
//   res_valid, res_ready  : result handshake
//   res_ones, res_timeouts: burst totals
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start with a non-zero burst length
// ARM   | cmp_rst high for RST_CYC cycles
// FLUSH | cmp_rst low, SYNC_STAGES cycles to clear stale synchroniser data
// WAIT  | up to TIMEOUT cycles for a resolved decision
// DONE  | totals valid, waiting for res_ready
module cmp_decision_sampler
    import cmp_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int RST_CYC     = DEF_RST_CYC,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] n_samples,
    output logic             busy,
    input  logic             cmp_pn,
    input  logic             cmp_nn,
    input  logic             cmp_xor,
    output logic             cmp_rst,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_ones,
    output logic [CNT_W-1:0] res_timeouts
);

    // One down-counting phase timer serves ARM, FLUSH and WAIT; it is loaded
    // with (length - 1) and each phase ends on its terminal count of zero.
    localparam int PH_MAX = max3(RST_CYC, SYNC_STAGES, TIMEOUT) - 1;
    localparam int PH_W   = (PH_MAX > 0) ? $clog2(PH_MAX + 1) : 1;

    localparam logic [PH_W-1:0] PH_ARM   = PH_W'(RST_CYC - 1);
    localparam logic [PH_W-1:0] PH_FLUSH = PH_W'(SYNC_STAGES - 1);
    localparam logic [PH_W-1:0] PH_WAIT  = PH_W'(TIMEOUT - 1);

    cmp_state_e       state_q, state_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    logic [CNT_W-1:0] remain_q, remain_d;
    logic [CNT_W-1:0] ones_q, ones_d;
    logic [CNT_W-1:0] touts_q, touts_d;

    logic s_pn, s_nn, s_xor;
    logic start_acc;
    logic resolved;
    logic phase_tc;
    logic sample_end;
    logic last_sample;
    logic one_bit;

    cmp_sync #(.STAGES(SYNC_STAGES)) u_sync_pn (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (cmp_pn),
        .q_o   (s_pn)
    );

    cmp_sync #(.STAGES(SYNC_STAGES)) u_sync_nn (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (cmp_nn),
        .q_o   (s_nn)
    );

    cmp_sync #(.STAGES(SYNC_STAGES)) u_sync_xor (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (cmp_xor),
        .q_o   (s_xor)
    );

    assign start_acc   = (state_q == ST_IDLE) && start && (n_samples != '0);
    // xor high while pn == nn is synchroniser skew between the chains, not a decision.
    assign resolved    = s_xor && (s_pn != s_nn);
    assign phase_tc    = (phase_q == '0);
    assign sample_end  = (state_q == ST_WAIT) && (resolved || phase_tc);
    assign last_sample = (remain_q == CNT_W'(1));
    // outp = 1 is signalled by outpn low.
    assign one_bit     = ~s_pn;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_acc) state_d = ST_ARM;
            ST_ARM:   if (phase_tc) state_d = ST_FLUSH;
            ST_FLUSH: if (phase_tc) state_d = ST_WAIT;
            ST_WAIT:  if (sample_end) state_d = last_sample ? ST_DONE : ST_ARM;
            ST_DONE:  if (res_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy         = (state_q == ST_ARM) || (state_q == ST_FLUSH) || (state_q == ST_WAIT);
        cmp_rst      = (state_q == ST_ARM);
        res_valid    = (state_q == ST_DONE);
        res_ones     = ones_q;
        res_timeouts = touts_q;
    end

    always_comb begin
        phase_d  = phase_q;
        remain_d = remain_q;
        ones_d   = ones_q;
        touts_d  = touts_q;
        case (state_q)
            ST_IDLE: begin
                if (start_acc) begin
                    phase_d  = PH_ARM;
                    remain_d = n_samples;
                    ones_d   = '0;
                    touts_d  = '0;
                end
            end
            ST_ARM: begin
                phase_d = phase_tc ? PH_FLUSH : phase_q - PH_W'(1);
            end
            ST_FLUSH: begin
                phase_d = phase_tc ? PH_WAIT : phase_q - PH_W'(1);
            end
            ST_WAIT: begin
                if (sample_end) begin
                    // Resolution wins over timeout on the final WAIT cycle.
                    if (resolved) begin
                        ones_d = ones_q + {{(CNT_W-1){1'b0}}, one_bit};
                    end else begin
                        touts_d = touts_q + CNT_W'(1);
                    end
                    remain_d = remain_q - CNT_W'(1);
                    phase_d  = PH_ARM;
                end else begin
                    phase_d = phase_q - PH_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= '0;
            remain_q <= '0;
            ones_q   <= '0;
            touts_q  <= '0;
        end else begin
            phase_q  <= phase_d;
            remain_q <= remain_d;
            ones_q   <= ones_d;
            touts_q  <= touts_d;
        end
    end

endmodule
